wb2axilite: RTL and testbench

//  Bridge from a pipelined Wishbone (B4) slave port to an AXI4-lite master port.

---
 rtl/wb2axilite_pkg.sv | 18 +
 rtl/wb2axilite.sv | 168 ++++++++++++++++
 tb/tb_wb2axilite.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb2axilite_pkg.sv
// wb2axilite_pkg: shared constants and helpers for the Wishbone to AXI4-lite bridge.
//   AXI_RESP_*       : AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   AXI_PROT_DEFAULT : protection bits driven on AWPROT/ARPROT
//   addr_lsb()       : number of byte-address bits below one data word
package wb2axilite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width) - 3;
  endfunction

endpackage

// File: rtl/wb2axilite.sv
// wb2axilite: pipelined Wishbone (B4) slave to AXI4-lite master bridge.
//   Tracks outstanding requests, returns in-order ack/err, and discards
//   responses that belong to a cycle the master aborted by dropping cyc.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   i_wb_cyc/stb/we       Wishbone cycle, strobe, write enable
//   i_wb_addr/data/sel    word address, write data, byte selects
//   o_wb_stall            request not accepted this cycle (combinational)
//   o_wb_ack/err/data     completion (OKAY / SLVERR-DECERR) and read data
//   M_AXI_AW*, M_AXI_W*   write address / write data channels
//   M_AXI_B*              write response channel (BREADY tied high)
//   M_AXI_AR*, M_AXI_R*   read address / read data channels (RREADY tied high)
// Build option:
//   WB2AXILITE_LOWPOWER_EN  zero AWADDR/WDATA/WSTRB/ARADDR while their VALID is
//                           low and zero o_wb_data except alongside o_wb_ack.
module wb2axilite
  import wb2axilite_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int LGDEPTH          = 5,
  localparam int ADDRLSB = addr_lsb(C_AXI_DATA_WIDTH),
  localparam int AWW     = C_AXI_ADDR_WIDTH - ADDRLSB,
  localparam int DW      = C_AXI_DATA_WIDTH
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  input  logic                        i_wb_we,
  input  logic [AWW-1:0]              i_wb_addr,
  input  logic [DW-1:0]               i_wb_data,
  input  logic [DW/8-1:0]             i_wb_sel,
  output logic                        o_wb_stall,
  output logic                        o_wb_ack,
  output logic                        o_wb_err,
  output logic [DW-1:0]               o_wb_data,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic [DW-1:0]               M_AXI_WDATA,
  output logic [DW/8-1:0]             M_AXI_WSTRB,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  input  logic [DW-1:0]               M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP
);

  localparam logic [LGDEPTH-1:0] NP_MAX = '1;

  logic [LGDEPTH-1:0] npending, npending_nxt;
  logic               flushing, dir;
  logic               accept, resp_valid, resp_good;
  logic [1:0]         resp;
  logic [AWW-1:0]     awaddr_q, araddr_q;

  assign M_AXI_BREADY = 1'b1;
  assign M_AXI_RREADY = 1'b1;
  assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
  assign M_AXI_ARPROT = AXI_PROT_DEFAULT;
  assign M_AXI_AWADDR = C_AXI_ADDR_WIDTH'(awaddr_q) << ADDRLSB;
  assign M_AXI_ARADDR = C_AXI_ADDR_WIDTH'(araddr_q) << ADDRLSB;

  // A direction change waits for the pipeline to drain so that responses
  // from the B and R channels can never interleave out of order.
  always_comb begin
    o_wb_stall = !i_wb_cyc || flushing
              || (npending == NP_MAX)
              || ((npending != '0) && (i_wb_we != dir))
              || (M_AXI_AWVALID && !M_AXI_AWREADY)
              || (M_AXI_WVALID  && !M_AXI_WREADY)
              || (M_AXI_ARVALID && !M_AXI_ARREADY);
  end

  assign accept     = i_wb_stb && i_wb_cyc && !o_wb_stall;
  assign resp_valid = M_AXI_BVALID || M_AXI_RVALID;
  assign resp       = M_AXI_BVALID ? M_AXI_BRESP : M_AXI_RRESP;
  assign resp_good  = resp_valid && i_wb_cyc && !flushing;

  always_comb begin
    npending_nxt = npending;
    if (accept && !resp_valid && (npending != NP_MAX))
      npending_nxt = npending + 1'b1;
    else if (!accept && resp_valid && (npending != '0))
      npending_nxt = npending - 1'b1;
  end

  // VALIDs are only ever cleared by their READY (or reset), never by an abort.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
    end else begin
      if (accept && i_wb_we) begin
        M_AXI_AWVALID <= 1'b1;
        M_AXI_WVALID  <= 1'b1;
      end else begin
        if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
        if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
      end
      if (accept && !i_wb_we)
        M_AXI_ARVALID <= 1'b1;
      else if (M_AXI_ARREADY)
        M_AXI_ARVALID <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (accept && i_wb_we) begin
      awaddr_q    <= i_wb_addr;
      M_AXI_WDATA <= i_wb_data;
      M_AXI_WSTRB <= i_wb_sel;
    end
`ifdef WB2AXILITE_LOWPOWER_EN
    else begin
      if (!M_AXI_AWVALID || M_AXI_AWREADY) awaddr_q <= '0;
      if (!M_AXI_WVALID  || M_AXI_WREADY) begin
        M_AXI_WDATA <= '0;
        M_AXI_WSTRB <= '0;
      end
    end
`endif
    if (accept && !i_wb_we)
      araddr_q <= i_wb_addr;
`ifdef WB2AXILITE_LOWPOWER_EN
    else if (!M_AXI_ARVALID || M_AXI_ARREADY)
      araddr_q <= '0;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
      npending  <= '0;
      flushing  <= 1'b0;
      dir       <= 1'b0;
    end else begin
      o_wb_ack <= resp_good && !resp[1];
      o_wb_err <= resp_good &&  resp[1];
`ifdef WB2AXILITE_LOWPOWER_EN
      o_wb_data <= (M_AXI_RVALID && resp_good && !resp[1]) ? M_AXI_RDATA : '0;
`else
      if (M_AXI_RVALID) o_wb_data <= M_AXI_RDATA;
`endif
      npending <= npending_nxt;
      // Responses still owed to an abandoned cycle must not leak into the next one.
      if (!i_wb_cyc && (npending_nxt != '0))
        flushing <= 1'b1;
      else if (npending_nxt == '0)
        flushing <= 1'b0;
      if (accept) dir <= i_wb_we;
    end
  end

endmodule

// File: tb/tb_wb2axilite.sv
module tb_wb2axilite;
  import wb2axilite_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int AWW = 30;

  logic            clk = 1'b0;
  logic            areset;
  logic            cyc, stb, we;
  logic [AWW-1:0]  wb_addr;
  logic [DW-1:0]   wb_wdata;
  logic [3:0]      wb_sel;
  logic            stall, ack, err;
  logic [DW-1:0]   wb_rdata;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic [DW-1:0]   wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;

  always #5 clk = ~clk;

  wb2axilite #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .LGDEPTH(5)) dut (
    .ACLK(clk), .ARESET(areset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(wb_rdata),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  typedef struct {
    logic           we;
    logic [AWW-1:0] addr;
    logic [DW-1:0]  data;
    logic [3:0]     sel;
    logic [1:0]     resp;
  } txn_t;

  txn_t req_q[$];               // master stimulus not yet accepted
  txn_t sb_q[$];                // scoreboard: accepted, awaiting response
  txn_t aw_q[$], w_q[$], ar_q[$]; // expected channel payloads
  txn_t b_q[$], r_q[$];         // slave: address taken, response owed
  int   w_cnt;

  int   n_vec, n_err;
  int   np_m;
  bit   flush_m;
  bit   cyc_en, aw_rdy_en, w_rdy_en, ar_rdy_en, b_hold, r_hold;
  bit   due_valid, due_ack, due_err, due_we;
  logic [DW-1:0] due_data;
  bit   last_stall, last_stb, last_acc, last_we;
  bit   s_awvalid, s_wvalid, s_arvalid;
  int   np_before, acc_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic w, input logic [AWW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, input logic [1:0] r);
    txn_t t;
    t.we = w; t.addr = a; t.data = d; t.sel = s; t.resp = r;
    req_q.push_back(t);
  endtask

  task automatic step();
    txn_t t;
    bit   resp_now;
    @(negedge clk);
    s_awvalid = awvalid; s_wvalid = wvalid; s_arvalid = arvalid;
    // outcome of the response driven in the previous cycle
    if (due_valid) begin
      check_val("ack", ack, due_ack);
      check_val("err", err, due_err);
      if (due_ack && !due_we) check_val("rdata", wb_rdata, due_data);
    end else if (ack || err) begin
      check_val("spurious_ackerr", {ack, err}, 2'b00);
    end
    due_valid = 0;
    // slave responses, in order
    resp_now = 0;
    bvalid = 0; rvalid = 0; bresp = 2'b00; rresp = 2'b00; rdata = $urandom;
    if (!b_hold && b_q.size() > 0 && w_cnt > 0) begin
      t = b_q.pop_front(); w_cnt--;
      bvalid = 1; bresp = t.resp; resp_now = 1;
    end else if (!r_hold && r_q.size() > 0) begin
      t = r_q.pop_front();
      rvalid = 1; rresp = t.resp; rdata = t.data; resp_now = 1;
    end
    // slave address/data acceptance
    awready = aw_rdy_en; wready = w_rdy_en; arready = ar_rdy_en;
    if (awvalid && awready) begin
      if (aw_q.size() == 0) check_val("aw_unexpected", 1, 0);
      else begin
        t = aw_q.pop_front();
        check_val("aw_addr", awaddr, {t.addr, 2'b00});
        check_val("aw_prot", awprot, 3'b000);
        b_q.push_back(t);
      end
    end
    if (wvalid && wready) begin
      if (w_q.size() == 0) check_val("w_unexpected", 1, 0);
      else begin
        t = w_q.pop_front();
        check_val("w_data", wdata, t.data);
        check_val("w_strb", wstrb, t.sel);
        w_cnt++;
      end
    end
    if (arvalid && arready) begin
      if (ar_q.size() == 0) check_val("ar_unexpected", 1, 0);
      else begin
        t = ar_q.pop_front();
        check_val("ar_addr", araddr, {t.addr, 2'b00});
        check_val("ar_prot", arprot, 3'b000);
        r_q.push_back(t);
      end
    end
    // master
    cyc = cyc_en; stb = 0;
    if (cyc_en && req_q.size() > 0) begin
      stb = 1; we = req_q[0].we; wb_addr = req_q[0].addr;
      wb_wdata = req_q[0].data; wb_sel = req_q[0].sel;
    end
    #1;
    last_stall = stall; last_stb = stb; last_we = we;
    last_acc = stb && cyc && !stall;
    np_before = np_m;
    if (last_acc) begin
      t = req_q.pop_front();
      check_val("np_limit", np_m < 31, 1);
      if (!t.we) t.data = $urandom;
      if (t.we) begin aw_q.push_back(t); w_q.push_back(t); end
      else ar_q.push_back(t);
      sb_q.push_back(t);
      np_m++; acc_cnt++;
    end
    if (resp_now) begin
      t = sb_q.pop_front();
      np_m--;
      due_valid = 1; due_we = t.we; due_data = t.data;
      due_ack = cyc && !flush_m && !t.resp[1];
      due_err = cyc && !flush_m &&  t.resp[1];
    end
    if (!cyc && np_m != 0) flush_m = 1;
    else if (np_m == 0) flush_m = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_q.size() > 0 || sb_q.size() > 0 || due_valid) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) check_val("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1; cyc = 0; stb = 0; we = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    @(negedge clk);
    s_awvalid = awvalid; s_wvalid = wvalid; s_arvalid = arvalid;
    @(negedge clk);
    areset = 0;
    req_q.delete(); sb_q.delete(); aw_q.delete(); w_q.delete(); ar_q.delete();
    b_q.delete(); r_q.delete();
    w_cnt = 0; np_m = 0; flush_m = 0; due_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stalled;
    n_vec = 0; n_err = 0; acc_cnt = 0;
    areset = 1; cyc = 0; stb = 0; we = 0; wb_addr = '0; wb_wdata = '0; wb_sel = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    cyc_en = 0; aw_rdy_en = 1; w_rdy_en = 1; ar_rdy_en = 1; b_hold = 0; r_hold = 0;
    do_reset();
    @(negedge clk);
    check_val("rst_ack", ack, 0);
    check_val("rst_err", err, 0);
    check_val("rst_data", wb_rdata, 0);
    check_val("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    check_val("rst_stall_nocyc", stall, 1);
    check_val("bready_rready", {bready, rready}, 2'b11);
    cyc_en = 1;

    // 1: single zero-wait write
    push_req(1, 30'h400, 32'hDEADBEEF, 4'hF, AXI_RESP_OKAY);
    step();
    check_val("t1_accept", last_acc, 1);
    step();
    check_val("t1_awwvalid", {s_awvalid, s_wvalid}, 2'b11);
    drain(20);

    // 2: four back-to-back reads with ARREADY low for 3 cycles
    ar_rdy_en = 0;
    for (int i = 0; i < 4; i++) push_req(0, 30'h100 + 30'(i), '0, 4'hF, AXI_RESP_OKAY);
    step();
    check_val("t2_accept", last_acc, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t2_stall", {last_stall, s_arvalid}, 2'b11);
    end
    ar_rdy_en = 1;
    drain(40);

    // 3: write immediately followed by read
    push_req(1, 30'h200, 32'h1234_5678, 4'h3, AXI_RESP_OKAY);
    push_req(0, 30'h201, '0, 4'hF, AXI_RESP_EXOKAY);
    stalled = 0; n = 0;
    do begin
      step(); n++;
      if (last_stb && !last_acc && !last_we) stalled++;
    end while (!(last_acc && !last_we) && n < 30);
    check_val("t3_read_accepted", last_acc && !last_we, 1);
    check_val("t3_np_at_read", np_before, 0);
    check_val("t3_read_stalled", stalled > 0, 1);
    drain(20);

    // 4: SLVERR on the middle of three reads
    push_req(0, 30'h300, '0, 4'hF, AXI_RESP_OKAY);
    push_req(0, 30'h301, '0, 4'hF, AXI_RESP_SLVERR);
    push_req(0, 30'h302, '0, 4'hF, AXI_RESP_OKAY);
    drain(30);

    // 5: abort with responses outstanding
    r_hold = 1;
    for (int i = 0; i < 3; i++) push_req(0, 30'h500 + 30'(i), '0, 4'hF, AXI_RESP_OKAY);
    n = 0;
    while (r_q.size() < 3 && n < 30) begin step(); n++; end
    check_val("t5_issued", r_q.size(), 3);
    r_hold = 0;
    step();
    cyc_en = 0; r_hold = 1;
    step();
    cyc_en = 1;
    step();
    check_val("t5_flush_stall", last_stall, 1);
    r_hold = 0;
    step();
    check_val("t5_flush_stall2", last_stall, 1);
    step();
    check_val("t5_flush_stall3", last_stall, 1);
    step();
    check_val("t5_flush_done", last_stall, 0);
    push_req(0, 30'h5A0, '0, 4'hF, AXI_RESP_OKAY);
    drain(20);

    // 6: fill to the outstanding limit, release one response, reset mid-burst
    b_hold = 1;
    for (int i = 0; i < 32; i++) push_req(1, 30'h800 + 30'(i), $urandom, 4'(i), AXI_RESP_OKAY);
    acc_cnt = 0; n = 0;
    while (acc_cnt < 31 && n < 100) begin step(); n++; end
    check_val("t6_fill", acc_cnt, 31);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t6_full_stall", last_stall, 1);
    end
    check_val("t6_held", acc_cnt, 31);
    aw_rdy_en = 0; w_rdy_en = 0; b_hold = 0;
    step();
    b_hold = 1;
    step();
    check_val("t6_one_more", acc_cnt, 32);
    step();
    check_val("t6_pending_valid", {s_awvalid, s_wvalid}, 2'b11);
    do_reset();
    check_val("t6_reset_drop", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
    aw_rdy_en = 1; w_rdy_en = 1; b_hold = 0;
    @(negedge clk);
    check_val("t6_post_rst_ackerr", {ack, err}, 2'b00);

    // sanity after reset: one write, one read
    push_req(1, 30'h0AB, 32'hCAFE_F00D, 4'h5, AXI_RESP_DECERR);
    push_req(0, 30'h0AC, '0, 4'hF, AXI_RESP_OKAY);
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
